rx_serial_7o1: RTL and testbench

//  UART receiver, 7 data bits, odd parity, 1 stop bit (7O1). Downstream peer of the sensor

---
 rtl/rx_serial_7o1.sv | 154 +++++++++++++++
 tb/tb_rx_serial_7o1.sv | 225 ++++++++++++++++++++++
 2 files changed

// File: rtl/rx_serial_7o1.sv
// 7O1 UART receiver: 2-FF input synchronizer, mid-bit sampling FSM, and a
// valid/ack character buffer with parity, framing and overrun flags.
module rx_serial_7o1 #(
  parameter int CLOCKS_PER_BIT = 434
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       entrada_serial,
  input  logic       recebido,
  output logic [6:0] dados_ascii,
  output logic       pronto,
  output logic       tem_dado,
  output logic       erro_paridade,
  output logic       erro_frame,
  output logic       erro_sobreposicao,
  output logic [3:0] db_estado
);

  localparam int CW = (CLOCKS_PER_BIT > 2) ? $clog2(CLOCKS_PER_BIT) : 1;
  localparam logic [CW-1:0] HALF_M1 = CW'(CLOCKS_PER_BIT / 2 - 1);
  localparam logic [CW-1:0] FULL_M1 = CW'(CLOCKS_PER_BIT - 1);

  typedef enum logic [3:0] {
    OCIOSO   = 4'd0,
    INICIO   = 4'd1,
    DADOS    = 4'd2,
    PARIDADE = 4'd3,
    PARADA   = 4'd4,
    FIM      = 4'd5,
    ESPERA   = 4'd6
  } state_t;

  state_t        state_q;
  logic [CW-1:0] cnt_q;
  logic [2:0]    idx_q;
  logic [6:0]    shift_q;
  logic          par_q;
  logic          sync1_q;
  logic          rx_s;
  logic [6:0]    dados_q;
  logic          pronto_q;
  logic          tem_dado_q;
  logic          erro_par_q;
  logic          erro_frame_q;
  logic          erro_sobre_q;
  logic          parity_ok;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      sync1_q <= 1'b1;
      rx_s    <= 1'b1;
    end else begin
      sync1_q <= entrada_serial;
      rx_s    <= sync1_q;
    end
  end

  // Odd parity: data plus parity bit must hold an odd number of ones.
  always_comb begin
    parity_ok = ^{shift_q, par_q};
  end

  // Handshake: a good frame raises tem_dado with dados_ascii stable; the
  // consumer pulses recebido to release it. Completion in the same cycle
  // as recebido keeps the new character and does not flag overrun.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q      <= OCIOSO;
      cnt_q        <= '0;
      idx_q        <= '0;
      shift_q      <= 7'h7f;
      par_q        <= 1'b1;
      dados_q      <= '0;
      pronto_q     <= 1'b0;
      tem_dado_q   <= 1'b0;
      erro_par_q   <= 1'b0;
      erro_frame_q <= 1'b0;
      erro_sobre_q <= 1'b0;
    end else begin
      pronto_q <= 1'b0;
      if (recebido) begin
        tem_dado_q   <= 1'b0;
        erro_sobre_q <= 1'b0;
      end
      case (state_q)
        OCIOSO: begin
          cnt_q <= '0;
          if (!rx_s) state_q <= INICIO;
        end
        INICIO: begin
          if (cnt_q == HALF_M1) begin
            cnt_q   <= '0;
            idx_q   <= '0;
            state_q <= rx_s ? OCIOSO : DADOS;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DADOS: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            shift_q <= {rx_s, shift_q[6:1]};
            idx_q   <= idx_q + 1'b1;
            if (idx_q == 3'd6) state_q <= PARIDADE;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PARIDADE: begin
          if (cnt_q == FULL_M1) begin
            cnt_q   <= '0;
            par_q   <= rx_s;
            state_q <= PARADA;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        PARADA: begin
          // Results are committed here so they are valid while FIM shows pronto.
          if (cnt_q == FULL_M1) begin
            cnt_q        <= '0;
            state_q      <= FIM;
            pronto_q     <= 1'b1;
            erro_par_q   <= ~parity_ok;
            erro_frame_q <= ~rx_s;
            if (parity_ok && rx_s) begin
              dados_q      <= shift_q;
              tem_dado_q   <= 1'b1;
              erro_sobre_q <= (erro_sobre_q | tem_dado_q) & ~recebido;
            end
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        FIM: begin
          state_q <= erro_frame_q ? ESPERA : OCIOSO;
        end
        ESPERA: begin
          if (rx_s) state_q <= OCIOSO;
        end
        default: state_q <= OCIOSO;
      endcase
    end
  end

  assign dados_ascii       = dados_q;
  assign pronto            = pronto_q;
  assign tem_dado          = tem_dado_q;
  assign erro_paridade     = erro_par_q;
  assign erro_frame        = erro_frame_q;
  assign erro_sobreposicao = erro_sobre_q;
  assign db_estado         = state_q;

endmodule

// File: tb/tb_rx_serial_7o1.sv
// Bench for rx_serial_7o1 at 16 clocks per bit: directed frames, a queue of
// expected frame results, and a monitor that checks each pronto pulse.
module tb_rx_serial_7o1;

  localparam int CPB = 16;

  logic       clock;
  logic       reset;
  logic       entrada_serial;
  logic       recebido;
  logic [6:0] dados_ascii;
  logic       pronto;
  logic       tem_dado;
  logic       erro_paridade;
  logic       erro_frame;
  logic       erro_sobreposicao;
  logic [3:0] db_estado;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int start_cyc = 0;
  int last_pronto_cyc = 0;
  logic prev_pronto = 1'b0;

  // Expected per frame: {data[6:0], erro_paridade, erro_frame, tem_dado, erro_sobreposicao}
  logic [10:0] exp_q[$];

  rx_serial_7o1 #(.CLOCKS_PER_BIT(CPB)) dut (
    .clock            (clock),
    .reset            (reset),
    .entrada_serial   (entrada_serial),
    .recebido         (recebido),
    .dados_ascii      (dados_ascii),
    .pronto           (pronto),
    .tem_dado         (tem_dado),
    .erro_paridade    (erro_paridade),
    .erro_frame       (erro_frame),
    .erro_sobreposicao(erro_sobreposicao),
    .db_estado        (db_estado)
  );

  // Clock and cycle counter
  initial clock = 1'b0;
  always #5 clock = ~clock;
  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) begin
      @(posedge clock);
      #1;
    end
  endtask

  task automatic drive_bit(input logic b);
    entrada_serial = b;
    wait_cycles(CPB);
  endtask

  // Called at posedge+1; leaves the line at the stop-bit value.
  task automatic send_frame(input logic [6:0] d, input logic p, input logic s);
    start_cyc = cyc;
    drive_bit(1'b0);
    for (int i = 0; i < 7; i++) drive_bit(d[i]);
    drive_bit(p);
    drive_bit(s);
  endtask

  task automatic pulse_ack();
    recebido = 1'b1;
    wait_cycles(1);
    recebido = 1'b0;
  endtask

  task automatic push_exp(input logic [6:0] d, input logic pe, input logic fe,
                          input logic td, input logic ov);
    exp_q.push_back({d, pe, fe, td, ov});
  endtask

  // Monitor / scoreboard
  initial begin
    logic [10:0] e;
    forever begin
      @(negedge clock);
      if (prev_pronto) check("pronto_one_cycle", {31'd0, pronto}, 32'd0);
      if (pronto && !prev_pronto) begin
        last_pronto_cyc = cyc;
        if (exp_q.size() == 0) begin
          check("unexpected_pronto", {31'd0, pronto}, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("dados_ascii", {25'd0, dados_ascii}, {25'd0, e[10:4]});
          check("erro_paridade", {31'd0, erro_paridade}, {31'd0, e[3]});
          check("erro_frame", {31'd0, erro_frame}, {31'd0, e[2]});
          check("tem_dado", {31'd0, tem_dado}, {31'd0, e[1]});
          check("erro_sobreposicao", {31'd0, erro_sobreposicao}, {31'd0, e[0]});
        end
      end
      prev_pronto = pronto;
    end
  end

  // Stimulus
  initial begin
    int n;
    reset = 1'b0;
    entrada_serial = 1'b1;
    recebido = 1'b0;
    wait_cycles(3);
    check("rst_dados", {25'd0, dados_ascii}, 32'd0);
    check("rst_flags", {27'd0, pronto, tem_dado, erro_paridade, erro_frame, erro_sobreposicao}, 32'd0);
    check("rst_estado", {28'd0, db_estado}, 32'd0);
    reset = 1'b1;
    wait_cycles(5);

    // 1: 'A' with correct parity; also frame-start to pronto latency
    push_exp(7'h41, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(7'h41, 1'b1, 1'b1);
    wait_cycles(5);
    check("pronto_latency", last_pronto_cyc - start_cyc, 32'd155);
    pulse_ack();
    wait_cycles(1);
    check("ack_clears_tem", {31'd0, tem_dado}, 32'd0);

    // 2: back-to-back "537s", consumer acks each character
    push_exp(7'h35, 1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(7'h33, 1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(7'h37, 1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(7'h73, 1'b0, 1'b0, 1'b1, 1'b0);
    fork
      begin
        send_frame(7'h35, 1'b1, 1'b1);
        send_frame(7'h33, 1'b1, 1'b1);
        send_frame(7'h37, 1'b0, 1'b1);
        send_frame(7'h73, 1'b0, 1'b1);
      end
      begin
        for (int k = 0; k < 4; k++) begin
          n = 0;
          @(negedge clock);
          while (!pronto && n < 400) begin
            @(negedge clock);
            n++;
          end
          check("b2b_pronto_seen", {31'd0, pronto}, 32'd1);
          @(posedge clock);
          #1;
          pulse_ack();
        end
      end
    join
    wait_cycles(4);

    // 3: parity error keeps the previous character, tem_dado stays 0
    push_exp(7'h73, 1'b1, 1'b0, 1'b0, 1'b0);
    send_frame(7'h41, 1'b0, 1'b1);
    wait_cycles(4);

    // 4: short glitch is rejected, then a framing error parks in ESPERA
    entrada_serial = 1'b0;
    wait_cycles(4);
    entrada_serial = 1'b1;
    wait_cycles(2);
    check("glitch_inicio", {28'd0, db_estado}, 32'd1);
    wait_cycles(20);
    check("glitch_ocioso", {28'd0, db_estado}, 32'd0);
    push_exp(7'h73, 1'b0, 1'b1, 1'b0, 1'b0);
    send_frame(7'h41, 1'b1, 1'b0);
    wait_cycles(40);
    check("espera_line_low", {28'd0, db_estado}, 32'd6);
    entrada_serial = 1'b1;
    wait_cycles(5);
    check("espera_exit", {28'd0, db_estado}, 32'd0);

    // 5: two good frames without ack -> overrun
    push_exp(7'h42, 1'b0, 1'b0, 1'b1, 1'b0);
    push_exp(7'h43, 1'b0, 1'b0, 1'b1, 1'b1);
    send_frame(7'h42, 1'b1, 1'b1);
    send_frame(7'h43, 1'b0, 1'b1);
    wait_cycles(4);
    pulse_ack();
    wait_cycles(1);
    check("ovr_ack_tem", {31'd0, tem_dado}, 32'd0);
    check("ovr_ack_sobre", {31'd0, erro_sobreposicao}, 32'd0);
    check("ovr_ack_dados", {25'd0, dados_ascii}, 32'h43);

    // 6: reset in the middle of the data bits, then a clean frame
    fork
      send_frame(7'h55, 1'b1, 1'b1);
      begin
        wait_cycles(60);
        check("mid_frame_dados_state", {28'd0, db_estado}, 32'd2);
        reset = 1'b0;
        #1;
        check("abort_dados", {25'd0, dados_ascii}, 32'd0);
        check("abort_flags", {27'd0, pronto, tem_dado, erro_paridade, erro_frame, erro_sobreposicao}, 32'd0);
        check("abort_estado", {28'd0, db_estado}, 32'd0);
      end
    join
    wait_cycles(5);
    reset = 1'b1;
    wait_cycles(10);
    push_exp(7'h73, 1'b0, 1'b0, 1'b1, 1'b0);
    send_frame(7'h73, 1'b0, 1'b1);

    n = 0;
    while (exp_q.size() != 0 && n < 400) begin
      wait_cycles(1);
      n++;
    end
    check("scoreboard_drained", exp_q.size(), 32'd0);
    wait_cycles(5);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
